// File: rtl/tpu_host_pkg.sv
// Shared types and sizes for the TPU host-side sequencer.
package tpu_host_pkg;

    typedef enum logic [2:0] {
        LOAD,
        WAIT_DONE,
        DRAIN,
        READ,
        SEND
    } state_t;

    localparam int NUM_OPERAND_BYTES = 8;
    localparam int NUM_RESULTS       = 4;

endpackage

// File: rtl/tpu_result_buf.sv
// 4x8 result register file: written during the controller read burst, drained through a read pointer.
// Read data is forced to 0 whenever it is not being presented.
module tpu_result_buf
    import tpu_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [1:0] i_widx,
    input  logic [7:0] i_wdata,
    input  logic       i_rd_en,
    input  logic       i_adv,
    output logic [7:0] o_rdata,
    output logic       o_last
);

    logic [7:0] r_mem [NUM_RESULTS];
    logic [1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_ptr <= 2'd0;
        end else begin
            if (i_we) begin
                r_mem[i_widx] <= i_wdata;
            end
            // The pointer wraps 3->0 exactly on the final accept, leaving it ready for the next burst.
            if (i_adv) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign o_rdata = i_rd_en ? r_mem[r_ptr] : 8'h00;
    assign o_last  = (r_ptr == 2'(NUM_RESULTS - 1));

endmodule

// File: rtl/tpu_host_seq.sv
// Host sequencer: streams 8 operand bytes into the TPU controller, waits for done, burst-reads 4 results
// and streams them out with valid/ready. Optional WAIT_DONE watchdog under TPU_SEQ_TIMEOUT_EN.
module tpu_host_seq
    import tpu_host_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
`ifdef TPU_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       ctrl_load_en,
    output logic       ctrl_load_sel_ab,
    output logic [1:0] ctrl_load_index,
    output logic [7:0] ctrl_in_data,
    input  logic       ctrl_done,
    output logic       ctrl_output_en,
    output logic [1:0] ctrl_output_sel,
    input  logic [7:0] ctrl_out_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       busy,
    output logic       err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t          r_state;
    logic [2:0]      r_byte_cnt;
    logic [1:0]      r_rd_idx;
    logic [DW-1:0]   r_drain;
    logic            r_load_en;
    logic            r_load_sel;
    logic [1:0]      r_load_idx;
    logic [7:0]      r_in_data;
    logic            w_last;
    logic            w_adv;

`ifdef TPU_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]   r_wd;
    logic            r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD;
            r_byte_cnt <= 3'd0;
            r_rd_idx   <= 2'd0;
            r_drain    <= '0;
            r_load_en  <= 1'b0;
            r_load_sel <= 1'b0;
            r_load_idx <= 2'd0;
            r_in_data  <= 8'h00;
`ifdef TPU_SEQ_TIMEOUT_EN
            r_wd       <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_load_en <= 1'b0;
`ifdef TPU_SEQ_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                LOAD: begin
                    if (s_valid) begin
                        r_load_en  <= 1'b1;
                        r_load_sel <= r_byte_cnt[2];
                        r_load_idx <= r_byte_cnt[1:0];
                        r_in_data  <= s_data;
                        if (r_byte_cnt == 3'(NUM_OPERAND_BYTES - 1)) begin
                            r_byte_cnt <= 3'd0;
                            r_state    <= WAIT_DONE;
`ifdef TPU_SEQ_TIMEOUT_EN
                            r_wd       <= '0;
`endif
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    // Read starts DRAIN_CYCLES after the done cycle; DRAIN covers all but the last of them.
                    if (ctrl_done) begin
                        if (DRAIN_CYCLES == 1) begin
                            r_state <= READ;
                        end else begin
                            r_state <= DRAIN;
                            r_drain <= DW'(DRAIN_CYCLES - 1);
                        end
                    end
`ifdef TPU_SEQ_TIMEOUT_EN
                    else if (r_wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= LOAD;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    r_drain <= r_drain - 1'b1;
                    if (r_drain == DW'(1)) begin
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_rd_idx <= r_rd_idx + 2'd1;
                    if (r_rd_idx == 2'(NUM_RESULTS - 1)) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (m_ready && w_last) begin
                        r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign w_adv = m_valid && m_ready;

    tpu_result_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (r_state == READ),
        .i_widx  (r_rd_idx),
        .i_wdata (ctrl_out_data),
        .i_rd_en (r_state == SEND),
        .i_adv   (w_adv),
        .o_rdata (m_data),
        .o_last  (w_last)
    );

    assign s_ready          = (r_state == LOAD);
    assign ctrl_load_en     = r_load_en;
    assign ctrl_load_sel_ab = r_load_sel;
    assign ctrl_load_index  = r_load_idx;
    assign ctrl_in_data     = r_in_data;
    assign ctrl_output_en   = (r_state == READ);
    assign ctrl_output_sel  = r_rd_idx;
    assign m_valid          = (r_state == SEND);
    assign busy             = !((r_state == LOAD) && (r_byte_cnt == 3'd0));
`ifdef TPU_SEQ_TIMEOUT_EN
    assign err              = r_err;
`else
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_host_seq.sv
// Randomized bench for tpu_host_seq with a transaction-level controller and host model.
`timescale 1ns/1ps
module tb_tpu_host_seq;

    localparam int DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic       ctrl_load_en, ctrl_load_sel_ab;
    logic [1:0] ctrl_load_index;
    logic [7:0] ctrl_in_data;
    logic       ctrl_done, ctrl_output_en;
    logic [1:0] ctrl_output_sel;
    logic [7:0] ctrl_out_data;
    logic       m_valid, m_ready;
    logic [7:0] m_data;
    logic       busy, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ops [8];
    logic [7:0] res [4];

    always #5 clk = ~clk;

    // Controller model: results are visible only while the read enable is high.
    always_comb ctrl_out_data = ctrl_output_en ? res[ctrl_output_sel] : 8'h5A;

    tpu_host_seq #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ctrl_load_en(ctrl_load_en), .ctrl_load_sel_ab(ctrl_load_sel_ab),
        .ctrl_load_index(ctrl_load_index), .ctrl_in_data(ctrl_in_data),
        .ctrl_done(ctrl_done), .ctrl_output_en(ctrl_output_en),
        .ctrl_output_sel(ctrl_output_sel), .ctrl_out_data(ctrl_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_s_ready"}, s_ready, 1);
        check_val({tag, "_load_en"}, ctrl_load_en, 0);
        check_val({tag, "_load_sel"}, ctrl_load_sel_ab, 0);
        check_val({tag, "_load_idx"}, ctrl_load_index, 0);
        check_val({tag, "_in_data"}, ctrl_in_data, 0);
        check_val({tag, "_out_en"}, ctrl_output_en, 0);
        check_val({tag, "_out_sel"}, ctrl_output_sel, 0);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_data"}, m_data, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    // mode 0: valid held high, 1: alternating 1,0,..., 2: random gaps
    task automatic do_load(input int mode);
        int         k = 0;
        int         cyc = 0;
        bit         pend = 0;
        logic [2:0] pk = 3'd0;
        logic [7:0] pd = 8'h00;
        while ((k < 8 || pend) && cyc < 200) begin
            step();
            case (mode)
                0:       s_valid = (k < 8);
                1:       s_valid = (k < 8) && (cyc % 2 == 0);
                default: s_valid = (k < 8) && ($urandom_range(0, 2) != 0);
            endcase
            s_data    = s_valid ? ops[k % 8] : 8'($urandom);
            ctrl_done = (k < 8) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            m_ready   = 1'($urandom);
            @(negedge clk);
            check_val("load_en", ctrl_load_en, pend);
            if (pend) begin
                check_val("load_sel", ctrl_load_sel_ab, pk[2]);
                check_val("load_idx", ctrl_load_index, pk[1:0]);
                check_val("load_data", ctrl_in_data, pd);
            end
            check_val("load_s_ready", s_ready, k < 8);
            check_val("load_busy", busy, k != 0);
            check_val("load_out_en", ctrl_output_en, 0);
            check_val("load_m_valid", m_valid, 0);
            check_val("load_err", err, 0);
            pend = s_valid && (k < 8);
            if (pend) begin
                pk = 3'(k);
                pd = ops[k % 8];
                k++;
            end
            cyc++;
        end
        if (cyc >= 200) check_val("load_timeout", 32'(cyc), 0);
        s_valid   = 1'b0;
        ctrl_done = 1'b0;
    endtask

    // pre idle WAIT_DONE cycles, then one done pulse; read burst expected DRAIN cycles later.
    task automatic do_compute(input int pre, input bit inject_rst);
        bit exp_en;
        for (int t = -pre; t <= DRAIN + 3; t++) begin
            step();
            s_valid   = 1'($urandom);
            s_data    = 8'($urandom);
            ctrl_done = (t == 0) ? 1'b1 : ((t > 0) ? 1'($urandom) : 1'b0);
            if (inject_rst && t == DRAIN + 2) begin
                rst = 1'b1;
                #1;
                check_reset("rst_mid");
                s_valid   = 1'b0;
                ctrl_done = 1'b0;
                return;
            end
            @(negedge clk);
            exp_en = (t >= DRAIN);
            check_val("rd_out_en", ctrl_output_en, exp_en);
            if (exp_en) check_val("rd_out_sel", ctrl_output_sel, 32'(t - DRAIN));
            check_val("rd_s_ready", s_ready, 0);
            check_val("rd_load_en", ctrl_load_en, 0);
            check_val("rd_m_valid", m_valid, 0);
            check_val("rd_busy", busy, 1);
            check_val("rd_err", err, 0);
        end
        ctrl_done = 1'b0;
    endtask

    // mode 0: random ready, 1: ready low 3 cycles while entry 1 is offered, 2: always ready
    task automatic do_send(input int mode);
        int j = 0;
        int cyc = 0;
        int stall = 0;
        while (j < 4 && cyc < 100) begin
            step();
            case (mode)
                0:       m_ready = 1'($urandom);
                1:       m_ready = !(j == 1 && stall < 3);
                default: m_ready = 1'b1;
            endcase
            ctrl_done = 1'($urandom);
            s_valid   = 1'($urandom);
            s_data    = 8'($urandom);
            @(negedge clk);
            check_val("snd_m_valid", m_valid, 1);
            check_val("snd_m_data", m_data, res[j]);
            check_val("snd_s_ready", s_ready, 0);
            check_val("snd_out_en", ctrl_output_en, 0);
            check_val("snd_load_en", ctrl_load_en, 0);
            if (mode == 1 && j == 1 && !m_ready) stall++;
            if (m_ready) j++;
            cyc++;
        end
        if (cyc >= 100) check_val("send_timeout", 32'(cyc), 0);
        if (mode == 1) check_val("snd_stall_cycles", 32'(stall), 3);
        step();
        s_valid   = 1'b0;
        ctrl_done = 1'b0;
        m_ready   = 1'b0;
        @(negedge clk);
        check_val("end_m_valid", m_valid, 0);
        check_val("end_m_data", m_data, 0);
        check_val("end_s_ready", s_ready, 1);
        check_val("end_busy", busy, 0);
    endtask

    task automatic set_fixed();
        for (int i = 0; i < 8; i++) ops[i] = 8'h11 + 8'(i);
        for (int i = 0; i < 4; i++) res[i] = 8'hA0 + 8'(i);
    endtask

    task automatic set_random();
        for (int i = 0; i < 8; i++) ops[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) res[i] = 8'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        ctrl_done = 1'b0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        set_fixed();
        do_load(0);
        do_compute(0, 1'b0);
        do_send(2);

        set_random();
        for (int i = 0; i < 4; i++) res[i] = 8'hA0 + 8'(i);
        do_load(1);
        do_compute(3, 1'b0);
        do_send(1);

        set_random();
        do_load(2);
        do_compute(1, 1'b1);
        step();
        @(negedge clk);
        check_reset("rst_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        set_fixed();
        do_load(0);
        do_compute(2, 1'b0);
        do_send(2);

        for (int n = 0; n < 20; n++) begin
            set_random();
            do_load(($urandom_range(0, 1) == 0) ? 1 : 2);
            do_compute(int'($urandom_range(0, 20)), 1'b0);
            do_send(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
